mem_stage_dm: RTL and testbench

- Memory-stage consumer of the EX/MEM pipeline register: takes the latched M-stage controls, ALU address and store data, and performs the data-memory access.
- Stores use byte-enable writes into a word-organised data memory.
- Loads read, select the addressed byte or halfword, and extend it. The result is registered at the MEM/WB boundary.
- Illegal accesses are detected, suppressed and reported through sticky error flags carrying the faulting PC.

---
 rtl/cpu_defs.sv | 40 ++++
 rtl/load_ext.sv | 47 ++++
 rtl/mem_stage_dm.sv | 101 ++++++++++
 tb/tb_mem_stage_dm.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: load size codes, WB source selects, store byte-enable patterns.
package cpu_defs;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam logic [1:0] MTR_MEM = 2'b01;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_B1   = 4'b0010;
  localparam logic [3:0] BE_B2   = 4'b0100;
  localparam logic [3:0] BE_B3   = 4'b1000;
  localparam logic [3:0] BE_H0   = 4'b0011;
  localparam logic [3:0] BE_H1   = 4'b1100;
  localparam logic [3:0] BE_W    = 4'b1111;

  typedef struct packed {
    logic align;
    logic range;
  } fault_t;

  function automatic logic be_legal(input logic [3:0] be);
    case (be)
      BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_W: be_legal = 1'b1;
      default:                                       be_legal = 1'b0;
    endcase
  endfunction

  // Replicate the unshifted store value across lanes according to the store size implied by be.
  function automatic logic [31:0] store_lanes(input logic [3:0] be, input logic [31:0] wd);
    case (be)
      BE_B0, BE_B1, BE_B2, BE_B3: store_lanes = {4{wd[7:0]}};
      BE_H0, BE_H1:               store_lanes = {2{wd[15:0]}};
      default:                    store_lanes = wd;
    endcase
  endfunction

endpackage

// File: rtl/load_ext.sv
// Combinational load formatter: selects byte/halfword from a memory word, extends it,
// and flags misaligned or illegal-size loads.
module load_ext
  import cpu_defs::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] data_c,
  output logic        align_err_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    data_c      = '0;
    align_err_c = 1'b0;
    case (size)
      SZ_WORD: begin
        align_err_c = (addr != 2'd0);
        data_c      = word;
      end
      SZ_HALF: begin
        align_err_c = addr[0];
        data_c      = {{16{sign & half_sel[15]}}, half_sel};
      end
      SZ_BYTE: begin
        data_c = {{24{sign & byte_sel[7]}}, byte_sel};
      end
      default: align_err_c = 1'b1;
    endcase
    if (align_err_c) data_c = '0;
  end

endmodule

// File: rtl/mem_stage_dm.sv
// Memory stage: byte-enable stores into a word-organised data memory, extended loads
// registered into W, and sticky fault flags with the PC of the first faulting access.
module mem_stage_dm
  import cpu_defs::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memwriteM,
  input  logic [1:0]  memtoregM,
  input  logic [1:0]  ext_sh_M,
  input  logic        ext_bh_M,
  input  logic [3:0]  BE_M,
  input  logic [31:0] ALU_outM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PC_8M,
  output logic [31:0] ReadDataW,
  output logic        align_err,
  output logic        range_err,
  output logic [31:0] err_pc
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;

  logic [31:0] mem [DEPTH];

  logic [31:0]           offset;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] widx;
  logic [31:0]           rd_word;
  logic                  is_load;
  logic                  is_store;
  logic [31:0]           ld_data;
  logic                  ld_align;
  fault_t                fault;
  logic                  wr_en;
  logic [31:0]           lanes;
  logic [31:0]           merged;
  logic                  unused_bits;

  // Offset wraps below BASE_ADDR, so such addresses fall outside LIMIT.
  assign offset      = ALU_outM - BASE_ADDR;
  assign in_range    = {1'b0, offset} < LIMIT;
  assign widx        = offset[DEPTH_LOG2+1:2];
  assign rd_word     = mem[widx];
  assign unused_bits = ^{offset[31:DEPTH_LOG2+2], offset[1:0]};

  assign is_load  = (memtoregM == MTR_MEM) && !memwriteM;
  assign is_store = memwriteM && (BE_M != BE_NONE);

  load_ext u_load_ext (
    .word        (rd_word),
    .addr        (ALU_outM[1:0]),
    .size        (ext_sh_M),
    .sign        (ext_bh_M),
    .data_c      (ld_data),
    .align_err_c (ld_align)
  );

  always_comb begin
    fault = '0;
    if (is_store) begin
      fault.align = !be_legal(BE_M);
      fault.range = !in_range;
    end else if (is_load) begin
      fault.align = ld_align;
      fault.range = !in_range;
    end
  end

  assign wr_en = is_store && (fault == '0);
  assign lanes = store_lanes(BE_M, WriteDataM);

  always_comb begin
    merged = rd_word;
    for (int b = 0; b < 4; b++) begin
      if (BE_M[b]) merged[8*b +: 8] = lanes[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      ReadDataW <= '0;
      align_err <= 1'b0;
      range_err <= 1'b0;
      err_pc    <= '0;
    end else begin
      if (wr_en) mem[widx] <= merged;
      ReadDataW <= (is_load && fault == '0) ? ld_data : '0;
      align_err <= align_err | fault.align;
      range_err <= range_err | fault.range;
      // Only the first fault since reset records its PC.
      if (!align_err && !range_err && fault != '0) err_pc <= PC_8M - 32'd8;
    end
  end

endmodule

// File: tb/tb_mem_stage_dm.sv
// Bench for mem_stage_dm: directed test-plan sequence, then random traffic against a
// byte-addressed reference model.
module tb_mem_stage_dm;

  localparam logic [1:0] W = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] B = 2'b10;

  logic        clk;
  logic        rst_n;
  logic        memwriteM;
  logic [1:0]  memtoregM;
  logic [1:0]  ext_sh_M;
  logic        ext_bh_M;
  logic [3:0]  BE_M;
  logic [31:0] ALU_outM;
  logic [31:0] WriteDataM;
  logic [31:0] PC_8M;
  logic [31:0] ReadDataW;
  logic        align_err;
  logic        range_err;
  logic [31:0] err_pc;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]  mdl [4096];
  logic [31:0] e_rd;
  logic        e_al;
  logic        e_rg;
  logic [31:0] e_pc;

  mem_stage_dm #(.DEPTH_LOG2(10), .BASE_ADDR(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .memwriteM  (memwriteM),
    .memtoregM  (memtoregM),
    .ext_sh_M   (ext_sh_M),
    .ext_bh_M   (ext_bh_M),
    .BE_M       (BE_M),
    .ALU_outM   (ALU_outM),
    .WriteDataM (WriteDataM),
    .PC_8M      (PC_8M),
    .ReadDataW  (ReadDataW),
    .align_err  (align_err),
    .range_err  (range_err),
    .err_pc     (err_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: memory as a flat byte array; sizes as byte counts.
  task automatic model(input logic r, input logic w, input logic [1:0] mtr, input logic [1:0] sh,
                       input logic bh, input logic [3:0] be, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] pc);
    logic        af, rf;
    logic [31:0] off, v;
    int          n, cnt;
    if (!r) begin
      foreach (mdl[i]) mdl[i] = 8'h00;
      e_rd = 0; e_al = 0; e_rg = 0; e_pc = 0;
      return;
    end
    af = 0; rf = 0; e_rd = 0;
    off = a - 32'h0000_0000;
    if (w) begin
      if (be != 4'b0000) begin
        af = !(be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
        rf = !(off < 32'd4096);
        if (!af && !rf) begin
          cnt = $countones(be);
          for (int i = 0; i < 4; i++)
            if (be[i])
              mdl[{off[11:2], 2'b00} + i] = (cnt == 1) ? wd[7:0] :
                                             (cnt == 2) ? wd[8*(i%2) +: 8] : wd[8*i +: 8];
        end
      end
    end else if (mtr == 2'b01) begin
      n  = (sh == 2'b00) ? 4 : (sh == 2'b01) ? 2 : (sh == 2'b10) ? 1 : 0;
      af = (n == 0) || (a % n != 0);
      rf = !(off < 32'd4096);
      if (!af && !rf) begin
        v = 0;
        for (int k = 0; k < n; k++) v = v | (32'(mdl[off[11:0] + k]) << (8*k));
        if (bh && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        e_rd = v;
      end
    end
    if ((af || rf) && !e_al && !e_rg) e_pc = pc - 8;
    e_al = e_al | af;
    e_rg = e_rg | rf;
  endtask

  task automatic cyc(input logic r, input logic w, input logic [1:0] mtr, input logic [1:0] sh,
                     input logic bh, input logic [3:0] be, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] pc);
    rst_n = r; memwriteM = w; memtoregM = mtr; ext_sh_M = sh; ext_bh_M = bh;
    BE_M = be; ALU_outM = a; WriteDataM = wd; PC_8M = pc;
    model(r, w, mtr, sh, bh, be, a, wd, pc);
    @(posedge clk);
    #1;
    check("rdata", ReadDataW, e_rd);
    check("align_err", 32'(align_err), 32'(e_al));
    check("range_err", 32'(range_err), 32'(e_rg));
    check("err_pc", err_pc, e_pc);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                    input logic [31:0] pc);
    cyc(1'b1, 1'b1, 2'b00, W, 1'b0, be, a, wd, pc);
  endtask

  task automatic ld(input logic [31:0] a, input logic [1:0] sh, input logic bh,
                    input logic [31:0] pc);
    cyc(1'b1, 1'b0, 2'b01, sh, bh, 4'b0000, a, 32'h0, pc);
  endtask

  task automatic rst_cycle();
    cyc(1'b0, 1'b0, 2'b00, W, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [3:0]  be_tab [8];
    logic        r, w, bh;
    logic [1:0]  mtr, sh;
    logic [3:0]  be;
    logic [31:0] a, wd, pc;
    int          kind;
    be_tab[0] = 4'b0001; be_tab[1] = 4'b0010; be_tab[2] = 4'b0100; be_tab[3] = 4'b1000;
    be_tab[4] = 4'b0011; be_tab[5] = 4'b1100; be_tab[6] = 4'b1111; be_tab[7] = 4'b0000;

    rst_cycle();
    rst_cycle();

    st(32'h10, 32'hDEAD_BEEF, 4'b1111, 32'h108);
    ld(32'h10, W, 1'b0, 32'h10C);
    check("tp_lw", ReadDataW, 32'hDEAD_BEEF);

    st(32'h13, 32'h0000_0080, 4'b1000, 32'h110);
    ld(32'h13, B, 1'b1, 32'h114);
    check("tp_lb", ReadDataW, 32'hFFFF_FF80);
    ld(32'h13, B, 1'b0, 32'h118);
    check("tp_lbu", ReadDataW, 32'h0000_0080);
    ld(32'h10, W, 1'b0, 32'h11C);
    check("tp_lw_merge", ReadDataW, 32'h80AD_BEEF);

    st(32'h22, 32'h0000_1234, 4'b1100, 32'h120);
    ld(32'h22, H, 1'b0, 32'h124);
    check("tp_lh", ReadDataW, 32'h0000_1234);
    ld(32'h21, H, 1'b0, 32'h200);
    check("tp_lh_mis_pc", err_pc, 32'h1F8);
    check("tp_lh_mis_flag", 32'(align_err), 32'd1);

    rst_cycle();
    st(32'h10, 32'h1111_2222, 4'b1111, 32'h300);
    st(32'h1000, 32'hCAFE_F00D, 4'b1111, 32'h304);
    check("tp_range_flag", 32'(range_err), 32'd1);
    check("tp_range_pc", err_pc, 32'h2FC);
    ld(32'h0, W, 1'b0, 32'h308);
    ld(32'hFFFF_FFFC, W, 1'b0, 32'h400);
    ld(32'h10, W, 1'b0, 32'h404);
    check("tp_range_nowrite", ReadDataW, 32'h1111_2222);

    rst_cycle();
    st(32'h30, 32'hFFFF_FFFF, 4'b0101, 32'h500);
    ld(32'h30, W, 1'b0, 32'h504);
    rst_cycle();
    st(32'h30, 32'hFFFF_FFFF, 4'b0000, 32'h508);
    ld(32'h30, W, 1'b0, 32'h50C);
    ld(32'h30, 2'b11, 1'b0, 32'h510);

    st(32'h40, 32'h5555_5555, 4'b1111, 32'h600);
    cyc(1'b1, 1'b1, 2'b01, W, 1'b0, 4'b1111, 32'h40, 32'hA5A5_A5A5, 32'h604);
    check("tp_st_ld_prio", ReadDataW, 32'h0);
    cyc(1'b0, 1'b1, 2'b00, W, 1'b0, 4'b1111, 32'h44, 32'h7777_7777, 32'h608);
    ld(32'h44, W, 1'b0, 32'h60C);
    ld(32'h40, W, 1'b0, 32'h610);
    check("tp_rst_clears", ReadDataW, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      r    = ($urandom_range(0, 249) != 0);
      kind = $urandom_range(0, 9);
      w    = (kind < 4);
      mtr  = (kind >= 3 && kind <= 7) ? 2'b01 : 2'($urandom_range(0, 3));
      sh   = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      bh   = 1'($urandom_range(0, 1));
      be   = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : be_tab[$urandom_range(0, 7)];
      case ($urandom_range(0, 19))
        0:       a = 32'h1000 + 32'($urandom_range(0, 255));
        1:       a = $urandom;
        2:       a = 32'h0FF0 + 32'($urandom_range(0, 15));
        default: a = 32'($urandom_range(0, 127));
      endcase
      if (!w && mtr == 2'b01 && $urandom_range(0, 1) == 1) begin
        if (sh == 2'b00) a[1:0] = 2'b00;
        else if (sh == 2'b01) a[0] = 1'b0;
      end
      wd = $urandom;
      pc = $urandom;
      cyc(r, w, mtr, sh, bh, be, a, wd, pc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
